// File: rtl/mcu_pkg.sv
// Shared MCU definitions: datapath widths, ALU function codes
// and the arbiter state encoding used by controller and ALU.
package mcu_pkg;

  localparam int FSEL_W = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 4;

  localparam logic [FSEL_W-1:0] FN_ADD = 4'h0;
  localparam logic [FSEL_W-1:0] FN_SUB = 4'h1;
  localparam logic [FSEL_W-1:0] FN_MUL = 4'h2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin winner select: first request at or after the
// priority pointer, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic found;
  int   i;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    i       = 0;
    for (int off = 0; off < NREQ; off++) begin
      i = int'(ptr) + off;
      if (i >= NREQ) i = i - NREQ;
      if (!found && req[i]) begin
        found      = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters with
// round-robin grant, registered operands and registered result.
module alu_arbiter
  import mcu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [FSEL_W*NREQ-1:0]   req_fsel,
  input  logic [DATA_W*NREQ-1:0]   req_a,
  input  logic [DATA_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [ACC_W-1:0]         result,
  output logic                     busy,
  output logic [FSEL_W-1:0]        alu_fsel,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [ACC_W-1:0]         alu_acc
);

  localparam int IDX_W = $clog2(NREQ);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               busy_q, busy_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic [FSEL_W-1:0]  fsel_q, fsel_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;

  logic [NREQ-1:0]    win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               last_cycle;

  logic [FSEL_W-1:0]  fsel_arr [NREQ];
  logic [DATA_W-1:0]  a_arr    [NREQ];
  logic [DATA_W-1:0]  b_arr    [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign fsel_arr[g] = req_fsel[g*FSEL_W +: FSEL_W];
    assign a_arr[g]    = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]    = req_b[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign any_req    = |req;
  assign last_cycle = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      widx_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      fsel_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      widx_q   <= widx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      fsel_q   <= fsel_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req)    state_d = ST_RUN;
      ST_RUN:  if (last_cycle) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    widx_d   = widx_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    result_d = result_q;
    fsel_d   = fsel_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d  = win_oh;
          busy_d = 1'b1;
          widx_d = win_idx;
          fsel_d = fsel_arr[win_idx];
          a_d    = a_arr[win_idx];
          b_d    = b_arr[win_idx];
          cnt_d  = CNT_W'(ALU_LAT - 1);
        end
      end
      ST_RUN: begin
        if (!last_cycle) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = alu_acc;
          done_d   = gnt_q;
          gnt_d    = '0;
          busy_d   = 1'b0;
          // pointer moves past the winner just served
          ptr_d    = (widx_q == IDX_W'(NREQ - 1))
                   ? '0 : widx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign result   = result_q;
  assign alu_fsel = fsel_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1,
// one with ALU_LAT=3, each driving a small behavioural ALU.
module tb_alu_arbiter;
  import mcu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0]  req_a1;
  logic [3:0]  f0_a1, f1_a1;
  logic [15:0] a0_a1, a1_a1, b0_a1, b1_a1;
  logic [1:0]  gnt_a1, done_a1;
  logic [31:0] res_a1, acc_a1;
  logic        busy_a1;
  logic [3:0]  af_a1;
  logic [15:0] aa_a1, ab_a1;

  logic [1:0]  req_b3;
  logic [3:0]  f0_b3, f1_b3;
  logic [15:0] a0_b3, a1_b3, b0_b3, b1_b3;
  logic [1:0]  gnt_b3, done_b3;
  logic [31:0] res_b3, acc_b3;
  logic        busy_b3;
  logic [3:0]  af_b3;
  logic [15:0] aa_b3, ab_b3;

  alu_arbiter #(.NREQ(2), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req(req_a1),
    .req_fsel({f1_a1, f0_a1}),
    .req_a({a1_a1, a0_a1}),
    .req_b({b1_a1, b0_a1}),
    .gnt(gnt_a1), .done(done_a1), .result(res_a1),
    .busy(busy_a1), .alu_fsel(af_a1), .alu_a(aa_a1),
    .alu_b(ab_a1), .alu_acc(acc_a1)
  );

  alu_arbiter #(.NREQ(2), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req_b3),
    .req_fsel({f1_b3, f0_b3}),
    .req_a({a1_b3, a0_b3}),
    .req_b({b1_b3, b0_b3}),
    .gnt(gnt_b3), .done(done_b3), .result(res_b3),
    .busy(busy_b3), .alu_fsel(af_b3), .alu_a(aa_b3),
    .alu_b(ab_b3), .alu_acc(acc_b3)
  );

  function automatic logic [31:0] alu_fn(
    input logic [3:0] f, input logic [15:0] x,
    input logic [15:0] y);
    logic [31:0] xe, ye;
    xe = {16'h0, x};
    ye = {16'h0, y};
    if (f == FN_ADD)      alu_fn = xe + ye;
    else if (f == FN_MUL) alu_fn = xe * ye;
    else                  alu_fn = 32'h0;
  endfunction

  assign acc_a1 = alu_fn(af_a1, aa_a1, ab_a1);
  assign acc_b3 = alu_fn(af_b3, aa_b3, ab_b3);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    req_a1 = '0; f0_a1 = '0; f1_a1 = '0;
    a0_a1 = '0; a1_a1 = '0; b0_a1 = '0; b1_a1 = '0;
    req_b3 = '0; f0_b3 = '0; f1_b3 = '0;
    a0_b3 = '0; a1_b3 = '0; b0_b3 = '0; b1_b3 = '0;

    step();
    step();
    chk("rst_gnt",    32'(gnt_a1),  32'h0);
    chk("rst_done",   32'(done_a1), 32'h0);
    chk("rst_busy",   32'(busy_a1), 32'h0);
    chk("rst_result", res_a1,       32'h0);
    chk("rst_alu_a",  32'(aa_a1),   32'h0);
    chk("rst_fsel",   32'(af_a1),   32'h0);
    rst = 1'b0;

    // single ADD 3+4
    req_a1 = 2'b01; f0_a1 = FN_ADD; a0_a1 = 16'h3; b0_a1 = 16'h4;
    step();
    chk("t1_gnt",   32'(gnt_a1),  32'h1);
    chk("t1_busy",  32'(busy_a1), 32'h1);
    chk("t1_done0", 32'(done_a1), 32'h0);
    chk("t1_alu_a", 32'(aa_a1),   32'h3);
    chk("t1_alu_b", 32'(ab_a1),   32'h4);
    step();
    chk("t1_done",   32'(done_a1), 32'h1);
    chk("t1_result", res_a1,       32'h7);
    chk("t1_gnt0",   32'(gnt_a1),  32'h0);
    chk("t1_busy0",  32'(busy_a1), 32'h0);
    req_a1 = 2'b00;
    step();
    chk("t1_pulse",  32'(done_a1), 32'h0);
    chk("t1_hold",   res_a1,       32'h7);
    chk("t1_alu_kp", 32'(aa_a1),   32'h3);

    // pointer back to 0 before the fairness run
    rst = 1'b1;
    step();
    rst = 1'b0;

    // both requesting: 0,1,0,1
    f0_a1 = FN_ADD; a0_a1 = 16'h1; b0_a1 = 16'h2;
    f1_a1 = FN_MUL; a1_a1 = 16'h3; b1_a1 = 16'h5;
    req_a1 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_gnt",  32'(gnt_a1),  (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_busy", 32'(busy_a1), 32'h1);
      step();
      chk("t2_done", 32'(done_a1), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_res",  res_a1,       (i % 2 == 0) ? 32'h3 : 32'hF);
      chk("t2_idle", 32'(gnt_a1),  32'h0);
      if (i == 3) req_a1 = 2'b00;
    end

    // requester 1 drops req mid-operation
    f1_a1 = FN_ADD; a1_a1 = 16'd10; b1_a1 = 16'd20;
    req_a1 = 2'b10;
    step();
    chk("t4_gnt", 32'(gnt_a1), 32'h2);
    req_a1 = 2'b00; a1_a1 = 16'd99;
    step();
    chk("t4_done", 32'(done_a1), 32'h2);
    chk("t4_res",  res_a1,       32'h1E);
    step();
    chk("t4_nogt", 32'(gnt_a1),  32'h0);
    chk("t4_busy", 32'(busy_a1), 32'h0);

    // full-width multiply
    f0_a1 = FN_MUL; a0_a1 = 16'hFFFF; b0_a1 = 16'hFFFF;
    req_a1 = 2'b01;
    step();
    chk("t6_gnt", 32'(gnt_a1), 32'h1);
    step();
    chk("t6_done", 32'(done_a1), 32'h1);
    chk("t6_res",  res_a1,       32'hFFFE_0001);
    req_a1 = 2'b00;
    step();

    // reset mid-RUN; pointer is 1 here
    f0_a1 = FN_ADD; a0_a1 = 16'h2; b0_a1 = 16'h2;
    req_a1 = 2'b11;
    step();
    chk("t5_gnt1", 32'(gnt_a1), 32'h2);
    rst = 1'b1;
    step();
    chk("t5_done", 32'(done_a1), 32'h0);
    chk("t5_gnt",  32'(gnt_a1),  32'h0);
    chk("t5_busy", 32'(busy_a1), 32'h0);
    chk("t5_res",  res_a1,       32'h0);
    rst = 1'b0;
    step();
    chk("t5_ptr0", 32'(gnt_a1), 32'h1);
    step();
    chk("t5_done0", 32'(done_a1), 32'h1);
    chk("t5_res4",  res_a1,       32'h4);
    req_a1 = 2'b00;
    step();

    // ALU_LAT=3, operand change after grant is ignored
    f0_b3 = FN_ADD; a0_b3 = 16'h5; b0_b3 = 16'h10;
    req_b3 = 2'b01;
    step();
    chk("t3_gnt",   32'(gnt_b3), 32'h1);
    chk("t3_alu_a", 32'(aa_b3),  32'h5);
    a0_b3 = 16'h9;
    step();
    chk("t3_d1",    32'(done_b3), 32'h0);
    chk("t3_alu_k", 32'(aa_b3),   32'h5);
    step();
    chk("t3_d2",   32'(done_b3), 32'h0);
    chk("t3_busy", 32'(busy_b3), 32'h1);
    step();
    chk("t3_done", 32'(done_b3), 32'h1);
    chk("t3_res",  res_b3,       32'h15);
    req_b3 = 2'b00;
    step();
    chk("t3_pulse", 32'(done_b3), 32'h0);
    chk("t3_idle",  32'(busy_b3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
